fft_stage_sequencer: RTL and testbench

//  Control FSM for the in-place radix-2 DIT FFT datapath behind the FFT_IP AXI4-Lite slave.
//  On a start pulse from the register block it runs LOG2N stages. Each stage issues N/2 butterfly

---
 rtl/fft_stage_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT datapath.
// Optional bit-reversed unload phase when FFT_SEQ_BITREV_EN is defined.
module fft_stage_sequencer #(
   parameter int WL     = 16,
   parameter int LOG2N  = 6,
   parameter int MAXOUT = 8
) (
   input  logic                       s_axi_aclk,
   input  logic                       s_axi_areset,
   input  logic                       start,
   input  logic                       abort,
   output logic                       bf_valid,
   input  logic                       bf_ready,
   output logic [LOG2N-1:0]           bf_addr_a,
   output logic [LOG2N-1:0]           bf_addr_b,
   output logic [LOG2N-2:0]           bf_tw_addr,
   output logic [$clog2(LOG2N)-1:0]   bf_stage,
   input  logic                       wb_done,
`ifdef FFT_SEQ_BITREV_EN
   output logic                       out_valid,
   output logic [LOG2N-1:0]           out_addr,
   input  logic                       out_ready,
`endif
   output logic                       busy,
   output logic                       done,
   output logic                       done_sticky,
   output logic                       err_wb
);

   localparam int SW = $clog2(LOG2N);
   localparam int KW = LOG2N - 1;
   localparam int OW = $clog2(MAXOUT + 1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
   localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
   // An out-of-range configuration never leaves IDLE
   localparam bit CFG_OK = (WL >= 1) && (LOG2N >= 2) && (LOG2N <= 10) &&
                           (MAXOUT >= 1) && (MAXOUT <= (1 << (LOG2N - 1)));

`ifdef FFT_SEQ_BITREV_EN
   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, UNLOAD, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
`endif

   state_t          state, state_nxt;
   logic [SW-1:0]   stage, stage_nxt;
   logic [KW-1:0]   k, k_nxt;
   logic [OW-1:0]   outstanding;
   logic            fire, wb_ok, start_acc;
   logic [KW-1:0]   stride_k, pos_k, tw;
   logic [LOG2N-1:0] a, b;

`ifdef FFT_SEQ_BITREV_EN
   logic [LOG2N-1:0] j, j_nxt, j_rev;
   logic             out_fire;
`endif

   assign fire      = bf_valid & bf_ready;
   assign wb_ok     = wb_done & (outstanding != '0);
   assign start_acc = (state == IDLE) & start & ~abort & CFG_OK;
   assign bf_valid  = (state == ISSUE) & (outstanding < OW'(MAXOUT));

   // stride_k wraps to 0 on the last stage, which turns the mask into all-ones
   assign stride_k = KW'(1) << stage;
   assign pos_k    = k & (stride_k - KW'(1));
   assign a        = ((({1'b0, k} >> stage) << stage) << 1) | {1'b0, pos_k};
   assign b        = a | (LOG2N'(1) << stage);
   assign tw       = pos_k << (LAST_STAGE - stage);

   assign bf_addr_a  = bf_valid ? a     : '0;
   assign bf_addr_b  = bf_valid ? b     : '0;
   assign bf_tw_addr = bf_valid ? tw    : '0;
   assign bf_stage   = bf_valid ? stage : '0;
   assign done       = (state == DONE);

`ifdef FFT_SEQ_BITREV_EN
   always_comb begin
      j_rev = '0;
      for (int i = 0; i < LOG2N; i++) j_rev[i] = j[LOG2N-1-i];
   end
   assign out_valid = (state == UNLOAD);
   assign out_addr  = out_valid ? j_rev : '0;
   assign out_fire  = out_valid & out_ready;
   assign busy      = (state == ISSUE) | (state == DRAIN) | (state == UNLOAD);
`else
   assign busy      = (state == ISSUE) | (state == DRAIN);
`endif

   always_comb begin
      state_nxt = state;
      stage_nxt = stage;
      k_nxt     = k;
`ifdef FFT_SEQ_BITREV_EN
      j_nxt     = j;
`endif
      if (abort) begin
         state_nxt = IDLE;
         stage_nxt = '0;
         k_nxt     = '0;
`ifdef FFT_SEQ_BITREV_EN
         j_nxt     = '0;
`endif
      end else begin
         case (state)
            IDLE: if (start_acc) begin
               state_nxt = ISSUE;
               stage_nxt = '0;
               k_nxt     = '0;
            end
            ISSUE: if (fire) begin
               k_nxt = k + KW'(1);
               if (k == K_LAST) state_nxt = DRAIN;
            end
            // Stage barrier: every writeback of this stage must be counted first
            DRAIN: if ((outstanding == '0) && !wb_done) begin
               k_nxt = '0;
               if (stage == LAST_STAGE) begin
`ifdef FFT_SEQ_BITREV_EN
                  state_nxt = UNLOAD;
                  j_nxt     = '0;
`else
                  state_nxt = DONE;
`endif
               end else begin
                  state_nxt = ISSUE;
                  stage_nxt = stage + SW'(1);
               end
            end
`ifdef FFT_SEQ_BITREV_EN
            UNLOAD: if (out_fire) begin
               j_nxt = j + LOG2N'(1);
               if (j == {LOG2N{1'b1}}) state_nxt = DONE;
            end
`endif
            DONE: begin
               state_nxt = IDLE;
               stage_nxt = '0;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         state <= IDLE;
         stage <= '0;
         k     <= '0;
`ifdef FFT_SEQ_BITREV_EN
         j     <= '0;
`endif
      end else begin
         state <= state_nxt;
         stage <= stage_nxt;
         k     <= k_nxt;
`ifdef FFT_SEQ_BITREV_EN
         j     <= j_nxt;
`endif
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         outstanding <= '0;
         done_sticky <= 1'b0;
         err_wb      <= 1'b0;
      end else begin
         if (abort) outstanding <= '0;
         else if (fire && !wb_ok) outstanding <= outstanding + OW'(1);
         else if (!fire && wb_ok) outstanding <= outstanding - OW'(1);

         if (start_acc) done_sticky <= 1'b0;
         else if ((state_nxt == DONE) && (state != DONE)) done_sticky <= 1'b1;

         if (start_acc) err_wb <= 1'b0;
         else if (wb_done && (outstanding == '0)) err_wb <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (N=8): address table, backpressure,
// in-flight limit, abort, writeback error and start-while-busy cases.
module tb_fft_stage_sequencer;
   localparam int LOG2N = 3;

   typedef struct {
      logic [1:0] stage;
      logic [2:0] a;
      logic [2:0] b;
      logic [1:0] tw;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic start = 1'b0, abort = 1'b0, bf_ready = 1'b0, wb_done = 1'b0;
   logic bf_valid, busy, done, done_sticky, err_wb;
   logic [2:0] bf_addr_a, bf_addr_b;
   logic [1:0] bf_tw_addr, bf_stage;
`ifdef FFT_SEQ_BITREV_EN
   logic out_valid, out_ready = 1'b1;
   logic [2:0] out_addr;
   logic [2:0] unl[$];
`endif

   logic start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1, wb2 = 1'b0;
   logic v2, busy2, done2, sticky2, err2;
   logic [2:0] a2, b2;
   logic [1:0] tw2, st2;

   vec_t vec[12];
   int tests = 0, fails = 0;
   int fidx = 0, wb_cnt = 0, done_cnt = 0, fires2;
   bit log_on = 0, auto_wb = 1, h0 = 0, h1 = 0;

   fft_stage_sequencer #(.WL(16), .LOG2N(LOG2N), .MAXOUT(4)) u_dut (
      .s_axi_aclk(clk), .s_axi_areset(rst), .start(start), .abort(abort),
      .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_addr_a(bf_addr_a),
      .bf_addr_b(bf_addr_b), .bf_tw_addr(bf_tw_addr), .bf_stage(bf_stage),
      .wb_done(wb_done),
`ifdef FFT_SEQ_BITREV_EN
      .out_valid(out_valid), .out_addr(out_addr), .out_ready(out_ready),
`endif
      .busy(busy), .done(done), .done_sticky(done_sticky), .err_wb(err_wb));

   fft_stage_sequencer #(.WL(16), .LOG2N(LOG2N), .MAXOUT(2)) u_dut2 (
      .s_axi_aclk(clk), .s_axi_areset(rst), .start(start2), .abort(abort2),
      .bf_valid(v2), .bf_ready(ready2), .bf_addr_a(a2), .bf_addr_b(b2),
      .bf_tw_addr(tw2), .bf_stage(st2), .wb_done(wb2),
`ifdef FFT_SEQ_BITREV_EN
      .out_valid(), .out_addr(), .out_ready(1'b1),
`endif
      .busy(busy2), .done(done2), .done_sticky(sticky2), .err_wb(err2));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Called at a negedge with inputs final; advances one clock to the next negedge.
   task automatic cyc();
      bit f;
      f = bf_valid & bf_ready & ~abort;
      if (f && log_on) begin
         if (fidx < 12) begin
            chk($sformatf("stage[%0d]", fidx), bf_stage, vec[fidx].stage);
            chk($sformatf("addr_a[%0d]", fidx), bf_addr_a, vec[fidx].a);
            chk($sformatf("addr_b[%0d]", fidx), bf_addr_b, vec[fidx].b);
            chk($sformatf("tw[%0d]", fidx), bf_tw_addr, vec[fidx].tw);
            if (vec[fidx].stage != 0)
               chk($sformatf("barrier[%0d]", fidx), wb_cnt >= 4 * vec[fidx].stage, 1);
         end else chk("extra_fire", fidx, 11);
         fidx++;
      end
`ifdef FFT_SEQ_BITREV_EN
      if (out_valid && out_ready && log_on) unl.push_back(out_addr);
`endif
      if (auto_wb) begin
         wb_done = h1;
         if (h1) wb_cnt++;
      end
      h1 = h0;
      h0 = f;
      @(negedge clk);
      if (done) begin
         done_cnt++;
         chk("sticky_with_done", done_sticky, 1);
      end
   endtask

   task automatic wait_done(input string nm);
      int n0;
      n0 = done_cnt;
      for (int i = 0; i < 300 && done_cnt == n0; i++) cyc();
      repeat (4) cyc();
      chk(nm, done_cnt - n0, 1);
   endtask

   initial begin
      vec[0]  = '{0, 0, 1, 0}; vec[1]  = '{0, 2, 3, 0};
      vec[2]  = '{0, 4, 5, 0}; vec[3]  = '{0, 6, 7, 0};
      vec[4]  = '{1, 0, 2, 0}; vec[5]  = '{1, 1, 3, 2};
      vec[6]  = '{1, 4, 6, 0}; vec[7]  = '{1, 5, 7, 2};
      vec[8]  = '{2, 0, 4, 0}; vec[9]  = '{2, 1, 5, 1};
      vec[10] = '{2, 2, 6, 2}; vec[11] = '{2, 3, 7, 3};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", bf_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sticky", done_sticky, 0);
      chk("rst_err", err_wb, 0);
      chk("rst_addr", {bf_addr_a, bf_addr_b, bf_tw_addr, bf_stage}, 0);
      rst = 1'b0;
      @(negedge clk);

      // full run, ready=1, writebacks 2 cycles after each fire
      log_on = 1; bf_ready = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      chk("busy_after_start", busy, 1);
      wait_done("t1_done_once");
      log_on = 0;
      chk("t1_fire_count", fidx, 12);
      chk("t1_sticky", done_sticky, 1);
      chk("t1_idle", busy, 0);
      chk("t1_err", err_wb, 0);
`ifdef FFT_SEQ_BITREV_EN
      chk("unload_len", unl.size(), 8);
      if (unl.size() == 8) begin
         chk("unl0", unl[0], 0); chk("unl1", unl[1], 4);
         chk("unl2", unl[2], 2); chk("unl3", unl[3], 6);
         chk("unl4", unl[4], 1); chk("unl5", unl[5], 5);
         chk("unl6", unl[6], 3); chk("unl7", unl[7], 7);
      end
`endif

      // backpressure on k=1
      bf_ready = 1'b0; wb_cnt = 0;
      start = 1'b1; cyc(); start = 1'b0;
      chk("t2_sticky_cleared", done_sticky, 0);
      bf_ready = 1'b1; cyc(); bf_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", bf_valid, 1);
         chk("t2_hold_ab", {bf_addr_a, bf_addr_b}, {3'd2, 3'd3});
         cyc();
      end
      chk("t2_k_still_1", bf_addr_a, 2);
      bf_ready = 1'b1;
      wait_done("t2_done_once");

      // in-flight limit on the MAXOUT=2 instance
      fires2 = 0;
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (v2 && ready2) fires2++;
         @(negedge clk);
      end
      chk("t3_fires", fires2, 2);
      chk("t3_stalled", v2, 0);
      wb2 = 1'b1; @(negedge clk); wb2 = 1'b0;
      chk("t3_resume", v2, 1);
      chk("t3_resume_addr", a2, 4);
      abort2 = 1'b1; @(negedge clk); abort2 = 1'b0;
      chk("t3_abort_idle", busy2, 0);

      // abort at stage1 k=2
      bf_ready = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 100 && !(bf_valid && bf_stage == 1 && bf_addr_a == 4); i++) cyc();
      chk("t4_reach_s1k2", {bf_stage, bf_addr_a}, {2'd1, 3'd4});
      fidx = done_cnt;
      abort = 1'b1; h0 = 0; h1 = 0; cyc(); abort = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_valid", bf_valid, 0);
      repeat (3) cyc();
      chk("t4_no_done", done_cnt, fidx);
      chk("t4_err", err_wb, 0);
      start = 1'b1; cyc(); start = 1'b0;
      chk("t4_restart", {bf_valid, bf_stage, bf_addr_a, bf_addr_b}, {1'b1, 2'd0, 3'd0, 3'd1});
      wait_done("t4_rerun_done");

      // spurious writeback, ignored start, simultaneous fire+writeback
      auto_wb = 0; bf_ready = 1'b0;
      wb_done = 1'b1; cyc(); wb_done = 1'b0;
      chk("t5_err", err_wb, 1);
      chk("t5_out_zero", u_dut.outstanding, 0);
      start = 1'b1; cyc(); start = 1'b0;
      chk("t5_err_cleared", err_wb, 0);
      bf_ready = 1'b1; cyc(); bf_ready = 1'b0;
      chk("t5_out_one", u_dut.outstanding, 1);
      chk("t5_k1", bf_addr_a, 2);
      start = 1'b1; cyc(); start = 1'b0;
      chk("t5_start_ignored", {busy, bf_stage, bf_addr_a}, {1'b1, 2'd0, 3'd2});
      bf_ready = 1'b1; wb_done = 1'b1; cyc(); bf_ready = 1'b0; wb_done = 1'b0;
      chk("t5_fire_wb_same", u_dut.outstanding, 1);
      chk("t5_k2", bf_addr_a, 4);
      abort = 1'b1; cyc(); abort = 1'b0;
      chk("t5_abort_clear", {busy, u_dut.outstanding}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
